mem_port_arbiter: RTL and testbench

Arbitrates the single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline. It sequences each access through a req/ack bus handshake and returns read data with a one-cycle valid pulse. It drives the per-stage stall signals that the hazard logic ORs into the pipeline-register enables. MEM is favoured because it holds the older instruction. A starvation counter bounds how long IF can be locked out, and a branch flush cancels an in-flight fetch without corrupting the bus.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, flush and memory-bus signals that
// surround the unified memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              stall_IF;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              stall_MEM;

  logic              flush;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush,
           bus_ack, bus_rdata,
    output if_rdata, if_valid, stall_IF, mem_rdata, mem_valid, stall_MEM,
           bus_req, bus_we, bus_addr, bus_wdata
  );

  // Pipeline stages plus memory side.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush,
           bus_ack, bus_rdata,
    input  if_rdata, if_valid, stall_IF, mem_rdata, mem_valid, stall_MEM,
           bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (IF) and
// load/store (MEM). MEM is favoured, bounded by a starvation counter, and a
// branch flush cancels an in-flight fetch by draining its bus cycle.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave arb
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_MEM, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              if_valid_q, mem_valid_q;
  logic              if_elig, mem_elig;
  logic              grant_if, grant_mem;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration and next-state decode. A port in its valid cycle is not
  // eligible, which forces a bubble between its back-to-back accesses.
  always_comb begin
    if_elig   = arb.if_req & ~if_valid_q & ~arb.flush;
    mem_elig  = arb.mem_req & ~mem_valid_q;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_elig && (!if_elig || starve_cnt < CNT_MAX)) begin
          grant_mem = 1'b1;
          state_nxt = GRANT_MEM;
        end else if (if_elig) begin
          grant_if  = 1'b1;
          state_nxt = GRANT_IF;
        end
      end
      GRANT_IF: begin
        if (arb.flush)        state_nxt = arb.bus_ack ? IDLE : DRAIN;
        else if (arb.bus_ack) state_nxt = IDLE;
      end
      GRANT_MEM, DRAIN: begin
        if (arb.bus_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus drive, stall and returned-data outputs.
  always_comb begin
    arb.bus_req   = (state != IDLE);
    arb.bus_we    = (state == GRANT_MEM) & lat_we;
    arb.bus_addr  = lat_addr;
    arb.bus_wdata = lat_wdata;
    arb.if_rdata  = if_rdata_q;
    arb.if_valid  = if_valid_q;
    arb.mem_rdata = mem_rdata_q;
    arb.mem_valid = mem_valid_q;
    arb.stall_IF  = arb.if_req & ~if_valid_q;
    arb.stall_MEM = arb.mem_req & ~mem_valid_q;
  end

  // Request latching, starvation counting and read-data capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt  <= '0;
      lat_addr    <= '0;
      lat_we      <= 1'b0;
      lat_wdata   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if (grant_mem) begin
        lat_addr  <= arb.mem_addr;
        lat_we    <= arb.mem_we;
        lat_wdata <= arb.mem_wdata;
        if (if_elig && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_if) begin
        lat_addr   <= arb.if_addr;
        lat_we     <= 1'b0;
        starve_cnt <= '0;
      end
      if (state == GRANT_IF && arb.bus_ack && !arb.flush) begin
        if_rdata_q <= arb.bus_rdata;
        if_valid_q <= 1'b1;
      end
      if (state == GRANT_MEM && arb.bus_ack) begin
        mem_valid_q <= 1'b1;
        if (!lat_we) mem_rdata_q <= arb.bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single transactions plus
// hand sequences for contention, starvation limit, flush and reset.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .arb  (bus_if)
  );

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] q_if[$];
  logic [31:0] q_mem[$];
  logic [31:0] exp_if  = '0;
  logic [31:0] exp_mem = '0;
  bit          order_mem[4];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every valid pulse is matched against the next queued expectation.
  task automatic mon();
    if (bus_if.mem_valid === 1'b1) begin
      if (q_mem.size() == 0) chk("mem_valid_unexpected", 32'(bus_if.mem_valid), 32'd0);
      else chk("mem_rdata", bus_if.mem_rdata, q_mem.pop_front());
    end
    if (bus_if.if_valid === 1'b1) begin
      if (q_if.size() == 0) chk("if_valid_unexpected", 32'(bus_if.if_valid), 32'd0);
      else chk("if_rdata", bus_if.if_rdata, q_if.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    mon();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.is_mem) begin
      bus_if.mem_req   = 1'b1;
      bus_if.mem_we    = v.we;
      bus_if.mem_addr  = v.addr;
      bus_if.mem_wdata = v.wdata;
      if (!v.we) exp_mem = v.rdata;
      q_mem.push_back(exp_mem);
    end else begin
      bus_if.if_req  = 1'b1;
      bus_if.if_addr = v.addr;
      exp_if = v.rdata;
      q_if.push_back(exp_if);
    end
    #1;
    chk($sformatf("v%0d_stall_c0", idx), 32'(v.is_mem ? bus_if.stall_MEM : bus_if.stall_IF), 32'd1);
    for (int c = 1; c <= v.ack_at; c++) begin
      tick();
      chk($sformatf("v%0d_bus_req_c%0d", idx, c), 32'(bus_if.bus_req), 32'd1);
      chk($sformatf("v%0d_bus_addr_c%0d", idx, c), bus_if.bus_addr, v.addr);
      chk($sformatf("v%0d_bus_we_c%0d", idx, c), 32'(bus_if.bus_we), 32'(v.is_mem & v.we));
      if (v.is_mem && v.we)
        chk($sformatf("v%0d_bus_wdata_c%0d", idx, c), bus_if.bus_wdata, v.wdata);
      if (c == v.ack_at) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = v.rdata;
      end
    end
    tick();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = $urandom;
    chk($sformatf("v%0d_valid", idx),
        32'(v.is_mem ? bus_if.mem_valid : bus_if.if_valid), 32'd1);
    chk($sformatf("v%0d_stall_valid_cycle", idx),
        32'(v.is_mem ? bus_if.stall_MEM : bus_if.stall_IF), 32'd0);
    chk($sformatf("v%0d_bus_req_after", idx), 32'(bus_if.bus_req), 32'd0);
    bus_if.if_req  = 1'b0;
    bus_if.mem_req = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_0000, 1};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0013, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         32'h00A0_0093, 2};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 1};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0208, 32'hA5A5_A5A5, 32'h0BAD_F00D, 2};
    order_mem[0] = 1'b1;
    order_mem[1] = 1'b0;
    order_mem[2] = 1'b1;
    order_mem[3] = 1'b0;

    bus_if.if_req = 1'b0;    bus_if.if_addr = '0;
    bus_if.mem_req = 1'b0;   bus_if.mem_we = 1'b0;
    bus_if.mem_addr = '0;    bus_if.mem_wdata = '0;
    bus_if.flush = 1'b0;     bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;

    // Reset state
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
    chk("rst_if_valid", 32'(bus_if.if_valid), 32'd0);
    chk("rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
    chk("rst_if_rdata", bus_if.if_rdata, 32'd0);
    chk("rst_mem_rdata", bus_if.mem_rdata, 32'd0);

    // Single transactions from the table
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    chk("store_keeps_mem_rdata", bus_if.mem_rdata, 32'hCAFE_F00D);

    // Both ports held: the valid-cycle bubble makes grants alternate
    bus_if.if_req = 1'b1;  bus_if.if_addr = 32'h0000_2000;
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h0000_0300;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("cont_g%0d_bus_req", g), 32'(bus_if.bus_req), 32'd1);
      chk($sformatf("cont_g%0d_bus_addr", g), bus_if.bus_addr,
          order_mem[g] ? 32'h0000_0300 : 32'h0000_2000);
      if (order_mem[g]) begin
        exp_mem = 32'hC0DE_0000 + 32'(g);
        q_mem.push_back(exp_mem);
      end else begin
        exp_if = 32'hC0DE_0000 + 32'(g);
        q_if.push_back(exp_if);
      end
      bus_if.bus_ack = 1'b1;
      bus_if.bus_rdata = 32'hC0DE_0000 + 32'(g);
      tick();
      bus_if.bus_ack = 1'b0;
      if (g == 3) begin
        bus_if.if_req = 1'b0;
        bus_if.mem_req = 1'b0;
      end
    end
    tick();
    chk("cont_end_bus_req", 32'(bus_if.bus_req), 32'd0);

    // Starvation limit: flush hides IF in MEM's valid cycle so MEM wins twice
    bus_if.if_req = 1'b1;  bus_if.if_addr = 32'h0000_3000;
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h0000_0400;
    tick();
    chk("starve_g1_addr", bus_if.bus_addr, 32'h0000_0400);
    exp_mem = 32'h1111_1111; q_mem.push_back(exp_mem);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1111_1111;
    tick();
    bus_if.bus_ack = 1'b0; bus_if.flush = 1'b1;
    tick();
    chk("starve_idle1_bus_req", 32'(bus_if.bus_req), 32'd0);
    bus_if.flush = 1'b0;
    tick();
    chk("starve_g2_bus_req", 32'(bus_if.bus_req), 32'd1);
    chk("starve_g2_addr", bus_if.bus_addr, 32'h0000_0400);
    exp_mem = 32'h2222_2222; q_mem.push_back(exp_mem);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h2222_2222;
    tick();
    bus_if.bus_ack = 1'b0; bus_if.flush = 1'b1;
    tick();
    chk("starve_idle2_bus_req", 32'(bus_if.bus_req), 32'd0);
    bus_if.flush = 1'b0;
    tick();
    chk("starve_limit_if_wins", bus_if.bus_addr, 32'h0000_3000);
    chk("starve_limit_bus_we", 32'(bus_if.bus_we), 32'd0);
    exp_if = 32'h3333_3333; q_if.push_back(exp_if);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h3333_3333;
    bus_if.mem_req = 1'b0;
    tick();
    bus_if.bus_ack = 1'b0; bus_if.if_req = 1'b0;
    tick();

    // Flush while a fetch is on the bus: drain until the late ack
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h0000_4000;
    tick();
    chk("drain_c1_bus_req", 32'(bus_if.bus_req), 32'd1);
    tick();
    bus_if.flush = 1'b1; bus_if.if_req = 1'b0;
    tick();
    bus_if.flush = 1'b0;
    chk("drain_c3_bus_req", 32'(bus_if.bus_req), 32'd1);
    chk("drain_c3_bus_addr", bus_if.bus_addr, 32'h0000_4000);
    tick();
    chk("drain_c4_bus_req", 32'(bus_if.bus_req), 32'd1);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hBADB_AD00;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("drain_c5_bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("drain_c5_if_valid", 32'(bus_if.if_valid), 32'd0);
    chk("drain_c5_if_rdata", bus_if.if_rdata, exp_if);

    // Flush in the same cycle as the fetch ack
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h0000_5000;
    tick();
    chk("flush_ack_c1_bus_req", 32'(bus_if.bus_req), 32'd1);
    bus_if.flush = 1'b1; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hBAD0_0001;
    tick();
    bus_if.flush = 1'b0; bus_if.bus_ack = 1'b0; bus_if.if_req = 1'b0;
    chk("flush_ack_if_valid", 32'(bus_if.if_valid), 32'd0);
    chk("flush_ack_if_rdata", bus_if.if_rdata, exp_if);
    chk("flush_ack_bus_req", 32'(bus_if.bus_req), 32'd0);
    tick();
    chk("flush_ack_idle_bus_req", 32'(bus_if.bus_req), 32'd0);

    // Reset in the middle of a store grant; the late ack must be ignored
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1;
    bus_if.mem_addr = 32'h0000_0600; bus_if.mem_wdata = 32'h0F0F_0F0F;
    tick();
    chk("rstmid_bus_req", 32'(bus_if.bus_req), 32'd1);
    chk("rstmid_bus_we", 32'(bus_if.bus_we), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1; bus_if.mem_req = 1'b0; bus_if.mem_we = 1'b0;
    exp_if = '0; exp_mem = '0;
    chk("rstmid_after_bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rstmid_after_bus_we", 32'(bus_if.bus_we), 32'd0);
    chk("rstmid_after_mem_valid", 32'(bus_if.mem_valid), 32'd0);
    chk("rstmid_after_mem_rdata", bus_if.mem_rdata, 32'd0);
    chk("rstmid_after_if_rdata", bus_if.if_rdata, 32'd0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h7777_7777;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("late_ack_mem_valid", 32'(bus_if.mem_valid), 32'd0);
    chk("late_ack_bus_req", 32'(bus_if.bus_req), 32'd0);
    tick();

    chk("q_mem_drained", 32'(q_mem.size()), 32'd0);
    chk("q_if_drained", 32'(q_if.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
